// File: rtl/imm_enc_if.sv
// Request/response bus of imm_encoder: valid/ready request in, valid/ready encoded word out.
// The master side drives requests and consumes results; the slave side is the encoder.
interface imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic        in_pcrel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_base, in_imm, in_pc, in_pcrel, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_base, in_imm, in_pc, in_pcrel, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// RV32E immediate packer with range/alignment checking, followed by an output FIFO with registered head.
// Build option IMM_ENC_ALIGN4_EN: B/J offsets must also be 4-byte aligned.
module imm_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_enc_if.slave         bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

`ifdef IMM_ENC_ALIGN4_EN
  localparam bit ALIGN4 = 1'b1;
`else
  localparam bit ALIGN4 = 1'b0;
`endif

  logic [31:0] off;
  logic [31:0] masked;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        range_ok;

  always_comb begin
    off       = bus.in_imm;
    masked    = bus.in_base;
    enc_instr = bus.in_base;
    range_ok  = 1'b0;
    if (bus.in_pcrel && (bus.in_fmt == FMT_B || bus.in_fmt == FMT_U || bus.in_fmt == FMT_J))
      off = bus.in_imm - bus.in_pc;
    case (bus.in_fmt)
      FMT_I: begin
        masked    = bus.in_base & 32'h000F_FFFF;
        range_ok  = (&off[31:11]) || !(|off[31:11]);
        enc_instr = masked | {off[11:0], 20'h0};
      end
      FMT_S: begin
        masked    = bus.in_base & 32'h01FF_F07F;
        range_ok  = (&off[31:11]) || !(|off[31:11]);
        enc_instr = masked | {off[11:5], 13'h0, off[4:0], 7'h0};
      end
      FMT_B: begin
        masked    = bus.in_base & 32'h01FF_F07F;
        range_ok  = ((&off[31:12]) || !(|off[31:12])) && !off[0] && !(ALIGN4 && off[1]);
        enc_instr = masked | {off[12], off[10:5], 13'h0, off[4:1], off[11], 7'h0};
      end
      FMT_U: begin
        masked    = bus.in_base & 32'h0000_0FFF;
        range_ok  = !(|off[11:0]);
        enc_instr = masked | {off[31:12], 12'h0};
      end
      FMT_J: begin
        masked    = bus.in_base & 32'h0000_0FFF;
        range_ok  = ((&off[31:20]) || !(|off[31:20])) && !off[0] && !(ALIGN4 && off[1]);
        enc_instr = masked | {off[20], off[10:1], off[11], off[19:12], 12'h0};
      end
      default: ;
    endcase
    // Illegal formats fall through with masked == in_base, so the word passes unmodified.
    enc_err = !range_ok;
    if (!range_ok)
      enc_instr = masked;
  end

  logic [31:0]      mem_instr [FIFO_DEPTH];
  logic             mem_err   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [OCC_W-1:0] occ, occ_next;
  logic             push, pop, full;
  logic             head_load;
  logic [31:0]      head_instr;
  logic             head_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (occ == OCC_W'(FIFO_DEPTH));
  assign pop          = bus.out_valid && bus.out_ready;
  assign bus.in_ready = !full || pop;
  assign push         = bus.in_valid && bus.in_ready;

  always_comb begin
    rd_next    = pop ? ptr_inc(rd_ptr) : rd_ptr;
    occ_next   = occ;
    head_load  = 1'b0;
    head_instr = enc_instr;
    head_err   = enc_err;
    case ({push, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
    // The next head is either a stored entry or, when that slot is being written now, the bypassed result.
    if (pop) begin
      head_load = (occ_next != '0);
      if (!(push && wr_ptr == rd_next)) begin
        head_instr = mem_instr[rd_next];
        head_err   = mem_err[rd_next];
      end
    end else if (occ == '0 && push) begin
      head_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= enc_instr;
      mem_err[wr_ptr]   <= enc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_err   <= 1'b0;
      enc_count     <= '0;
      err_count     <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr        <= rd_next;
      occ           <= occ_next;
      bus.out_valid <= (occ_next != '0);
      if (head_load) begin
        bus.out_instr <= head_instr;
        bus.out_err   <= head_err;
      end
      if (pop) begin
        if (bus.out_err) begin
          if (err_count != '1)
            err_count <= err_count + 1'b1;
        end else if (enc_count != '1) begin
          enc_count <= enc_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table, scoreboard queue, backpressure and reset sequences.
module tb_imm_encoder;
  localparam int DEPTH = 2;
  localparam int CW    = 3;
  localparam int NV    = 19;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pcrel;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] enc_count, err_count;

  imm_enc_if bus();

  imm_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  vec_t vecs [NV];
  exp_t sbq [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   exp_enc = 0;
  int   exp_errc = 0;
  int   waited;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pops are predicted half a cycle ahead: out_valid && out_ready at the falling edge means a pop next rise.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", bus.out_instr);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_instr", bus.out_instr, mon_e.instr);
        chk("out_err", {31'b0, bus.out_err}, {31'b0, mon_e.err});
        if (mon_e.err) begin
          if (exp_errc != (1 << CW) - 1) exp_errc++;
        end else begin
          if (exp_enc != (1 << CW) - 1) exp_enc++;
        end
      end
    end
  end

  task automatic send(input int i, output int w);
    bit   accepted;
    exp_t e;
    accepted      = 1'b0;
    w             = 0;
    bus.in_fmt    = vecs[i].fmt;
    bus.in_base   = vecs[i].base;
    bus.in_imm    = vecs[i].imm;
    bus.in_pc     = vecs[i].pc;
    bus.in_pcrel  = vecs[i].pcrel;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.instr = vecs[i].exp_instr;
        e.err   = vecs[i].exp_err;
        sbq.push_back(e);
        accepted = 1'b1;
      end else begin
        w++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout vec=%0d actual=stalled required=accepted", i);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (sbq.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0,        1'b0, 32'hFFF0_0013, 1'b0};
    vecs[1]  = '{3'd2, 32'h0000_0063, 32'h0000_0100, 32'h108,      1'b1, 32'hFE00_0CE3, 1'b0};
    vecs[2]  = '{3'd0, 32'h0000_0013, 32'h0000_0800, 32'h0,        1'b0, 32'h0000_0013, 1'b1};
    vecs[3]  = '{3'd6, 32'hABCD_E013, 32'h0000_0000, 32'h0,        1'b0, 32'hABCD_E013, 1'b1};
    vecs[4]  = '{3'd3, 32'h0000_02B7, 32'h1234_5000, 32'h0,        1'b0, 32'h1234_52B7, 1'b0};
    vecs[5]  = '{3'd3, 32'h0000_02B7, 32'h1234_5001, 32'h0,        1'b0, 32'h0000_02B7, 1'b1};
    vecs[6]  = '{3'd4, 32'h0000_00EF, 32'h0000_1000, 32'h0,        1'b1, 32'h0000_10EF, 1'b0};
`ifdef IMM_ENC_ALIGN4_EN
    vecs[7]  = '{3'd4, 32'h0000_00EF, 32'h0000_0006, 32'h0,        1'b0, 32'h0000_00EF, 1'b1};
`else
    vecs[7]  = '{3'd4, 32'h0000_00EF, 32'h0000_0006, 32'h0,        1'b0, 32'h0060_00EF, 1'b0};
`endif
    vecs[8]  = '{3'd0, 32'hFFF0_0093, 32'h0000_07FF, 32'h0,        1'b0, 32'h7FF0_0093, 1'b0};
    vecs[9]  = '{3'd0, 32'h0000_0013, 32'hFFFF_F800, 32'h0,        1'b0, 32'h8000_0013, 1'b0};
    vecs[10] = '{3'd1, 32'hFE00_0FA3, 32'h0000_07E5, 32'h1000,     1'b1, 32'h7E00_02A3, 1'b0};
    vecs[11] = '{3'd1, 32'h0000_0023, 32'hFFFF_F7FF, 32'h0,        1'b0, 32'h0000_0023, 1'b1};
    vecs[12] = '{3'd2, 32'h0000_0063, 32'h0000_0FFC, 32'h0,        1'b0, 32'h7E00_0EE3, 1'b0};
    vecs[13] = '{3'd2, 32'h0000_0063, 32'h0000_1000, 32'h0,        1'b0, 32'h0000_0063, 1'b1};
    vecs[14] = '{3'd2, 32'h0000_0063, 32'h0000_0003, 32'h0,        1'b0, 32'h0000_0063, 1'b1};
    vecs[15] = '{3'd4, 32'h0000_00EF, 32'hFFF0_0000, 32'h0,        1'b0, 32'h8000_00EF, 1'b0};
    vecs[16] = '{3'd4, 32'h0000_00EF, 32'h0010_0000, 32'h0,        1'b0, 32'h0000_00EF, 1'b1};
    vecs[17] = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'h0,        1'b0, 32'h1234_5678, 1'b1};
    vecs[18] = '{3'd3, 32'h0000_0517, 32'h0000_1000, 32'h3000,     1'b1, 32'hFFFF_E517, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_fmt    = 3'd0;
    bus.in_base   = '0;
    bus.in_imm    = '0;
    bus.in_pc     = '0;
    bus.in_pcrel  = 1'b0;
    bus.out_ready = 1'b0;

    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    chk("rst_enc_count", {29'b0, enc_count}, 32'd0);
    chk("rst_err_count", {29'b0, err_count}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // I-type with latency: head valid in the cycle right after acceptance.
    bus.out_ready = 1'b1;
    send(0, waited);
    idle();
    chk("latency_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("latency_out_instr", bus.out_instr, 32'hFFF0_0013);
    @(posedge clk);
    #1;
    chk("t1_enc_count", {29'b0, enc_count}, 32'd1);
    chk("t1_empty", {31'b0, bus.out_valid}, 32'd0);

    send(1, waited); idle(); drain();
    chk("t2_enc_count", {29'b0, enc_count}, 32'd2);
    send(2, waited); idle(); drain();
    chk("t3_err_count", {29'b0, err_count}, 32'd1);
    send(3, waited); idle(); drain();
    chk("t3_err_count_fmt", {29'b0, err_count}, 32'd2);

    for (int i = 4; i < NV; i++) send(i, waited);
    idle();
    drain();
    chk("sat_enc_count", {29'b0, enc_count}, 32'd7);
    chk("sat_err_count", {29'b0, err_count}, 32'd7);
    chk("model_enc_count", {29'b0, enc_count}, exp_enc);
    chk("model_err_count", {29'b0, err_count}, exp_errc);

    // Backpressure: fill the FIFO, then stream with a pop and a push every cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(i == 0 ? 0 : 4, waited);
    idle();
    chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    send(6, waited);  chk("stream_no_stall", waited, 32'd0);
    send(8, waited);  chk("stream_no_stall", waited, 32'd0);
    send(9, waited);  chk("stream_no_stall", waited, 32'd0);
    send(15, waited); chk("stream_no_stall", waited, 32'd0);
    send(1, waited);  chk("stream_no_stall", waited, 32'd0);
    idle();
    drain();
    chk("stream_empty", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset while two entries are held.
    bus.out_ready = 1'b0;
    send(4, waited);
    send(6, waited);
    idle();
    chk("pre_rst_out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_out_instr", bus.out_instr, 32'd0);
    chk("midrst_enc_count", {29'b0, enc_count}, 32'd0);
    chk("midrst_err_count", {29'b0, err_count}, 32'd0);
    sbq.delete();
    exp_enc  = 0;
    exp_errc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    send(9, waited);
    idle();
    drain();
    chk("post_rst_enc_count", {29'b0, enc_count}, 32'd1);
    chk("post_rst_err_count", {29'b0, err_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
